// File: rtl/load_store_unit.sv
// Memory-access stage: one Wishbone classic cycle per load/store, with byte-lane
// steering, load sign extension, and fault reporting for misalignment, bus error and timeout.
module load_store_unit #(
  parameter  int NUM_REGS = 64,
  parameter  int TIMEOUT  = 255,
  localparam int RI       = $clog2(NUM_REGS)
) (
  input  logic          wb_clk_i,
  input  logic          rst,
  input  logic          is_load,
  input  logic          is_store,
  input  logic [31:0]   loadstore_address,
  input  logic [1:0]    loadstore_size,
  input  logic          sign_extend,
  input  logic [RI-1:0] loadstore_dest,
  input  logic [31:0]   store_data,
  output logic          busy,
  output logic          wr_en,
  output logic [RI-1:0] wr_idx,
  output logic [31:0]   wr_val,
  output logic          fault,
  output logic [31:0]   fault_addr,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [31:0]   wb_adr_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [RI-1:0] dest_q, dest_d;
  logic          load_q, load_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          wb_we_q, wb_we_d;
  logic [31:0]   wb_adr_q, wb_adr_d;
  logic [3:0]    wb_sel_q, wb_sel_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic          wr_en_q, wr_en_d;
  logic [RI-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]   wr_val_q, wr_val_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;

  logic          req;
  logic          misaligned;
  logic [1:0]    req_off;
  logic [3:0]    req_sel;
  logic [31:0]   req_dat;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;

  assign req     = is_load | is_store;
  assign req_off = loadstore_address[1:0];
  assign busy    = ((state_q == IDLE) && req) || (state_q == BUS);

  always_comb begin
    misaligned = 1'b0;
    req_sel    = 4'b1111;
    req_dat    = store_data;
    case (loadstore_size)
      2'd0: begin
        req_sel = 4'b0001 << req_off;
        req_dat = {4{store_data[7:0]}};
      end
      2'd1: begin
        misaligned = req_off[0];
        req_sel    = 4'b0011 << req_off;
        req_dat    = {2{store_data[15:0]}};
      end
      2'd2:    misaligned = (req_off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Offset comes from the latched address; the bus inputs are only live in BUS.
  always_comb begin
    rd_shift = wb_dat_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_val = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_val = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sext_d       = sext_q;
    dest_d       = dest_q;
    load_d       = load_q;
    wb_cyc_d     = wb_cyc_q;
    wb_we_d      = wb_we_q;
    wb_adr_d     = wb_adr_q;
    wb_sel_d     = wb_sel_q;
    wb_dat_d     = wb_dat_q;
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_val_d     = wr_val_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = loadstore_address;
          size_d = loadstore_size;
          sext_d = sign_extend;
          dest_d = loadstore_dest;
          load_d = is_load;
          if (misaligned) begin
            state_d      = DONE;
            fault_d      = 1'b1;
            fault_addr_d = loadstore_address;
          end else begin
            state_d  = BUS;
            cnt_d    = '0;
            wb_cyc_d = 1'b1;
            wb_we_d  = is_store;
            wb_adr_d = {loadstore_address[31:2], 2'b00};
            wb_sel_d = req_sel;
            wb_dat_d = req_dat;
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (wb_err_i || (!wb_ack_i && cnt_q == TO_LAST)) begin
          state_d      = DONE;
          wb_cyc_d     = 1'b0;
          wb_we_d      = 1'b0;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
        end else if (wb_ack_i) begin
          state_d  = DONE;
          wb_cyc_d = 1'b0;
          wb_we_d  = 1'b0;
          if (load_q) begin
            wr_en_d  = 1'b1;
            wr_idx_d = dest_q;
            wr_val_d = load_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      sext_q       <= 1'b0;
      dest_q       <= '0;
      load_q       <= 1'b0;
      wb_cyc_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_adr_q     <= '0;
      wb_sel_q     <= '0;
      wb_dat_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_val_q     <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      dest_q       <= dest_d;
      load_q       <= load_d;
      wb_cyc_q     <= wb_cyc_d;
      wb_we_q      <= wb_we_d;
      wb_adr_q     <= wb_adr_d;
      wb_sel_q     <= wb_sel_d;
      wb_dat_q     <= wb_dat_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_val_q     <= wr_val_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign wb_cyc_o   = wb_cyc_q;
  assign wb_stb_o   = wb_cyc_q;
  assign wb_we_o    = wb_we_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_sel_o   = wb_sel_q;
  assign wb_dat_o   = wb_dat_q;
  assign wr_en      = wr_en_q;
  assign wr_idx     = wr_idx_q;
  assign wr_val     = wr_val_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; the bench plays the Wishbone slave cycle by cycle.
module tb_load_store_unit;

  localparam int RI = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          is_load, is_store;
  logic [31:0]   loadstore_address;
  logic [1:0]    loadstore_size;
  logic          sign_extend;
  logic [RI-1:0] loadstore_dest;
  logic [31:0]   store_data;
  logic          busy, wr_en, fault;
  logic [RI-1:0] wr_idx;
  logic [31:0]   wr_val, fault_addr;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]   wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i, wb_err_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.NUM_REGS(64), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .rst(rst), .is_load(is_load), .is_store(is_store),
    .loadstore_address(loadstore_address), .loadstore_size(loadstore_size),
    .sign_extend(sign_extend), .loadstore_dest(loadstore_dest), .store_data(store_data),
    .busy(busy), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .fault(fault), .fault_addr(fault_addr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic req(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                     input logic sx, input logic [RI-1:0] d, input logic [31:0] sd);
    is_load = ld; is_store = ~ld; loadstore_address = a; loadstore_size = sz;
    sign_extend = sx; loadstore_dest = d; store_data = sd;
  endtask

  task automatic drop_req();
    is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drop_req(); wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    loadstore_address = '0; loadstore_size = '0; sign_extend = 1'b0;
    loadstore_dest = '0; store_data = '0;
    step(); step();
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'b0, wb_we_o}, 32'd0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_val", wr_val, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_byte_load_sext();
    int busy_cycles = 0;
    req(1'b1, 32'h0000_1003, 2'd0, 1'b1, 6'd5, '0);
    #1;
    chk("bl_busy_req", {31'b0, busy}, 32'd1);
    busy_cycles += int'(busy);
    step();
    busy_cycles += int'(busy);
    chk("bl_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("bl_stb", {31'b0, wb_stb_o}, 32'd1);
    chk("bl_we", {31'b0, wb_we_o}, 32'd0);
    chk("bl_sel", {28'b0, wb_sel_o}, 32'h8);
    chk("bl_adr", wb_adr_o, 32'h0000_1000);
    wb_dat_i = 32'h80FF_FFFF; wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    busy_cycles += int'(busy);
    chk("bl_wr_en", {31'b0, wr_en}, 32'd1);
    chk("bl_wr_idx", {26'b0, wr_idx}, 32'd5);
    chk("bl_wr_val", wr_val, 32'hFFFF_FF80);
    chk("bl_cyc_done", {31'b0, wb_cyc_o}, 32'd0);
    drop_req();
    step();
    busy_cycles += int'(busy);
    chk("bl_wr_en_once", {31'b0, wr_en}, 32'd0);
    chk("bl_busy_cycles", busy_cycles, 32'd2);
  endtask

  task automatic test_half_store();
    req(1'b0, 32'h0000_2002, 2'd1, 1'b0, 6'd0, 32'h1234_ABCD);
    step();
    chk("hs_we", {31'b0, wb_we_o}, 32'd1);
    chk("hs_sel", {28'b0, wb_sel_o}, 32'hC);
    chk("hs_dat", wb_dat_o, 32'hABCD_ABCD);
    chk("hs_adr", wb_adr_o, 32'h0000_2000);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("hs_no_wr", {31'b0, wr_en}, 32'd0);
    chk("hs_no_fault", {31'b0, fault}, 32'd0);
    drop_req();
    step();
  endtask

  task automatic test_misaligned();
    req(1'b1, 32'h0000_0006, 2'd2, 1'b0, 6'd9, '0);
    step();
    chk("mis_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_fault_addr", fault_addr, 32'h0000_0006);
    chk("mis_wr_en", {31'b0, wr_en}, 32'd0);
    chk("mis_busy_done", {31'b0, busy}, 32'd0);
    drop_req();
    step();
    chk("mis_fault_pulse", {31'b0, fault}, 32'd0);
    chk("mis_cyc_after", {31'b0, wb_cyc_o}, 32'd0);
  endtask

  task automatic test_timeout();
    req(1'b1, 32'h0000_0100, 2'd2, 1'b0, 6'd1, '0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_cyc_%0d", i), {31'b0, wb_cyc_o}, 32'd1);
      chk($sformatf("to_busy_%0d", i), {31'b0, busy}, 32'd1);
      step();
    end
    chk("to_fault", {31'b0, fault}, 32'd1);
    chk("to_fault_addr", fault_addr, 32'h0000_0100);
    chk("to_busy_done", {31'b0, busy}, 32'd0);
    chk("to_cyc_done", {31'b0, wb_cyc_o}, 32'd0);
    chk("to_wr_en", {31'b0, wr_en}, 32'd0);
    drop_req();
    step();
    req(1'b1, 32'h0000_0200, 2'd2, 1'b0, 6'd7, '0);
    step();
    wb_dat_i = 32'hCAFE_BABE; wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("to_next_wr_en", {31'b0, wr_en}, 32'd1);
    chk("to_next_wr_idx", {26'b0, wr_idx}, 32'd7);
    chk("to_next_wr_val", wr_val, 32'hCAFE_BABE);
    chk("to_next_fault", {31'b0, fault}, 32'd0);
    drop_req();
    step();
  endtask

  task automatic test_bus_error();
    req(1'b1, 32'h0000_0300, 2'd0, 1'b0, 6'd3, '0);
    step();
    step();
    chk("err_cyc_2nd", {31'b0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1111_1111;
    step();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk("err_fault", {31'b0, fault}, 32'd1);
    chk("err_wr_en", {31'b0, wr_en}, 32'd0);
    chk("err_fault_addr", fault_addr, 32'h0000_0300);
    drop_req();
    step();
  endtask

  task automatic test_back_to_back();
    req(1'b1, 32'h0000_0402, 2'd0, 1'b0, 6'd2, '0);
    step();
    wb_dat_i = 32'h00C3_0000; wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("b2b_wr_val", wr_val, 32'h0000_00C3);
    req(1'b0, 32'h0000_0501, 2'd0, 1'b0, 6'd0, 32'h0000_00A5);
    #1;
    chk("b2b_busy_in_done", {31'b0, busy}, 32'd0);
    step();
    chk("b2b_busy_idle", {31'b0, busy}, 32'd1);
    step();
    chk("b2b_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("b2b_sel", {28'b0, wb_sel_o}, 32'h2);
    chk("b2b_dat", wb_dat_o, 32'hA5A5_A5A5);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    drop_req();
    step();
  endtask

  task automatic test_reset_mid_bus();
    req(1'b1, 32'h0000_0400, 2'd2, 1'b0, 6'd4, '0);
    step();
    chk("rmb_cyc_before", {31'b0, wb_cyc_o}, 32'd1);
    rst = 1'b1; drop_req();
    step();
    rst = 1'b0;
    chk("rmb_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rmb_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rmb_wr_en_%0d", i), {31'b0, wr_en}, 32'd0);
      chk($sformatf("rmb_fault_%0d", i), {31'b0, fault}, 32'd0);
      step();
    end
    req(1'b1, 32'h0000_0010, 2'd1, 1'b0, 6'd6, '0);
    step();
    chk("rmb_half_sel", {28'b0, wb_sel_o}, 32'h3);
    wb_dat_i = 32'hBEEF_8001; wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("rmb_half_wr_en", {31'b0, wr_en}, 32'd1);
    chk("rmb_half_wr_val", wr_val, 32'h0000_8001);
    drop_req();
    step();
  endtask

  initial begin
    test_reset();
    test_byte_load_sext();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_back_to_back();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
